// File: rtl/axis_demux_64_4.sv
// 64-bit AXI-Stream frame demultiplexer, one input to four outputs.
// A route (or discard) is chosen once per frame and held until tlast; the output side is a two-entry skid.
//
// state  | meaning
// IDLE   | no frame open; waiting for enable & tvalid to latch select/drop
// ACTIVE | frame open; beats flow to select_reg (or are discarded) until tlast
module axis_demux_64_4 #(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = 1,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  enable,
  input  logic                  drop,
  input  logic [1:0]            select,

  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,

  output logic [DATA_WIDTH-1:0] output_0_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_0_axis_tkeep,
  output logic                  output_0_axis_tvalid,
  input  logic                  output_0_axis_tready,
  output logic                  output_0_axis_tlast,
  output logic                  output_0_axis_tuser,

  output logic [DATA_WIDTH-1:0] output_1_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_1_axis_tkeep,
  output logic                  output_1_axis_tvalid,
  input  logic                  output_1_axis_tready,
  output logic                  output_1_axis_tlast,
  output logic                  output_1_axis_tuser,

  output logic [DATA_WIDTH-1:0] output_2_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_2_axis_tkeep,
  output logic                  output_2_axis_tvalid,
  input  logic                  output_2_axis_tready,
  output logic                  output_2_axis_tlast,
  output logic                  output_2_axis_tuser,

  output logic [DATA_WIDTH-1:0] output_3_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_3_axis_tkeep,
  output logic                  output_3_axis_tvalid,
  input  logic                  output_3_axis_tready,
  output logic                  output_3_axis_tlast,
  output logic                  output_3_axis_tuser
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      select_reg, select_next;
  logic            drop_reg, drop_next;
  logic            frame_reg;

  logic            out_ready_int_reg, out_ready_int_early;
  logic            out_valid_reg, out_valid_next;
  logic            temp_valid_reg, temp_valid_next;
  logic            store_int_to_out, store_int_to_temp, store_temp_to_out;

  logic [DATA_WIDTH-1:0] out_data_reg, temp_data_reg;
  logic [KEEP_WIDTH-1:0] out_keep_reg, temp_keep_reg;
  logic                  out_last_reg, temp_last_reg;
  logic                  out_user_reg, temp_user_reg;
  logic [1:0]            out_sel_reg, temp_sel_reg;

  logic                  in_ready;
  logic                  xfer;
  logic                  int_valid;
  logic                  cur_ready;
  logic [3:0]            out_tready_vec;
  logic [KEEP_WIDTH-1:0] keep_in;
  logic [KEEP_WIDTH-1:0] keep_out;

  assign frame_reg = (state_reg == ACTIVE);
  assign in_ready  = frame_reg & (drop_reg | out_ready_int_reg);
  assign input_axis_tready = in_ready;
  assign xfer      = input_axis_tvalid & in_ready;
  assign int_valid = xfer & ~drop_reg;
  assign keep_in   = (KEEP_ENABLE != 0) ? input_axis_tkeep : '1;

  // The output register remembers which port its beat belongs to, so a beat
  // still draining from the previous frame keeps its own destination.
  assign out_tready_vec = {output_3_axis_tready, output_2_axis_tready,
                           output_1_axis_tready, output_0_axis_tready};
  assign cur_ready      = out_tready_vec[out_sel_reg];

  always_comb begin
    state_next  = state_reg;
    select_next = select_reg;
    drop_next   = drop_reg;
    case (state_reg)
      IDLE: begin
        if (enable && input_axis_tvalid) begin
          state_next  = ACTIVE;
          select_next = select;
          drop_next   = drop;
        end
      end
      ACTIVE: begin
        if (xfer && input_axis_tlast) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid_next      = out_valid_reg;
    temp_valid_next     = temp_valid_reg;
    store_int_to_out    = 1'b0;
    store_int_to_temp   = 1'b0;
    store_temp_to_out   = 1'b0;
    out_ready_int_early = cur_ready | (~temp_valid_reg & (~out_valid_reg | ~int_valid));

    if (out_ready_int_reg) begin
      if (cur_ready || !out_valid_reg) begin
        out_valid_next   = int_valid;
        store_int_to_out = int_valid;
      end else begin
        temp_valid_next   = int_valid;
        store_int_to_temp = int_valid;
      end
    end else if (cur_ready) begin
      out_valid_next    = temp_valid_reg;
      temp_valid_next   = 1'b0;
      store_temp_to_out = temp_valid_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      select_reg        <= 2'd0;
      drop_reg          <= 1'b0;
      out_ready_int_reg <= 1'b0;
      out_valid_reg     <= 1'b0;
      temp_valid_reg    <= 1'b0;
      out_data_reg      <= '0;
      out_keep_reg      <= '0;
      out_last_reg      <= 1'b0;
      out_user_reg      <= 1'b0;
      out_sel_reg       <= 2'd0;
      temp_data_reg     <= '0;
      temp_keep_reg     <= '0;
      temp_last_reg     <= 1'b0;
      temp_user_reg     <= 1'b0;
      temp_sel_reg      <= 2'd0;
    end else begin
      state_reg         <= state_next;
      select_reg        <= select_next;
      drop_reg          <= drop_next;
      out_ready_int_reg <= out_ready_int_early;
      out_valid_reg     <= out_valid_next;
      temp_valid_reg    <= temp_valid_next;

      if (store_int_to_out) begin
        out_data_reg <= input_axis_tdata;
        out_keep_reg <= keep_in;
        out_last_reg <= input_axis_tlast;
        out_user_reg <= input_axis_tuser;
        out_sel_reg  <= select_reg;
      end else if (store_temp_to_out) begin
        out_data_reg <= temp_data_reg;
        out_keep_reg <= temp_keep_reg;
        out_last_reg <= temp_last_reg;
        out_user_reg <= temp_user_reg;
        out_sel_reg  <= temp_sel_reg;
      end

      if (store_int_to_temp) begin
        temp_data_reg <= input_axis_tdata;
        temp_keep_reg <= keep_in;
        temp_last_reg <= input_axis_tlast;
        temp_user_reg <= input_axis_tuser;
        temp_sel_reg  <= select_reg;
      end
    end
  end

  assign keep_out = (KEEP_ENABLE != 0) ? out_keep_reg : '1;

  assign output_0_axis_tdata  = out_data_reg;
  assign output_0_axis_tkeep  = keep_out;
  assign output_0_axis_tvalid = out_valid_reg & (out_sel_reg == 2'd0);
  assign output_0_axis_tlast  = out_last_reg;
  assign output_0_axis_tuser  = out_user_reg;

  assign output_1_axis_tdata  = out_data_reg;
  assign output_1_axis_tkeep  = keep_out;
  assign output_1_axis_tvalid = out_valid_reg & (out_sel_reg == 2'd1);
  assign output_1_axis_tlast  = out_last_reg;
  assign output_1_axis_tuser  = out_user_reg;

  assign output_2_axis_tdata  = out_data_reg;
  assign output_2_axis_tkeep  = keep_out;
  assign output_2_axis_tvalid = out_valid_reg & (out_sel_reg == 2'd2);
  assign output_2_axis_tlast  = out_last_reg;
  assign output_2_axis_tuser  = out_user_reg;

  assign output_3_axis_tdata  = out_data_reg;
  assign output_3_axis_tkeep  = keep_out;
  assign output_3_axis_tvalid = out_valid_reg & (out_sel_reg == 2'd3);
  assign output_3_axis_tlast  = out_last_reg;
  assign output_3_axis_tuser  = out_user_reg;

endmodule

// File: tb/tb_axis_demux_64_4.sv
// Directed bench for axis_demux_64_4: routing, discard, back-pressure and frame spacing.
module tb_axis_demux_64_4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        drop = 1'b0;
  logic [1:0]  select = 2'd0;
  logic [63:0] in_tdata = '0;
  logic [7:0]  in_tkeep = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tlast = 1'b0;
  logic        in_tuser = 1'b0;
  wire         in_tready;

  wire  [63:0] o_tdata [4];
  wire  [7:0]  o_tkeep [4];
  wire  [3:0]  o_tvalid;
  wire  [3:0]  o_tlast;
  wire  [3:0]  o_tuser;
  logic [3:0]  o_tready = 4'hF;

  int checks = 0;
  int errors = 0;

  logic [75:0] obs [$];
  int          vcount [4];
  logic        stall_prev [4];
  logic [75:0] held_beat [4];

  int first_x, last_x, n_x;
  bit toggle0 = 1'b0;
  bit chk_first = 1'b0;

  always #5 clk = ~clk;

  axis_demux_64_4 dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .drop                 (drop),
    .select               (select),
    .input_axis_tdata     (in_tdata),
    .input_axis_tkeep     (in_tkeep),
    .input_axis_tvalid    (in_tvalid),
    .input_axis_tready    (in_tready),
    .input_axis_tlast     (in_tlast),
    .input_axis_tuser     (in_tuser),
    .output_0_axis_tdata  (o_tdata[0]),
    .output_0_axis_tkeep  (o_tkeep[0]),
    .output_0_axis_tvalid (o_tvalid[0]),
    .output_0_axis_tready (o_tready[0]),
    .output_0_axis_tlast  (o_tlast[0]),
    .output_0_axis_tuser  (o_tuser[0]),
    .output_1_axis_tdata  (o_tdata[1]),
    .output_1_axis_tkeep  (o_tkeep[1]),
    .output_1_axis_tvalid (o_tvalid[1]),
    .output_1_axis_tready (o_tready[1]),
    .output_1_axis_tlast  (o_tlast[1]),
    .output_1_axis_tuser  (o_tuser[1]),
    .output_2_axis_tdata  (o_tdata[2]),
    .output_2_axis_tkeep  (o_tkeep[2]),
    .output_2_axis_tvalid (o_tvalid[2]),
    .output_2_axis_tready (o_tready[2]),
    .output_2_axis_tlast  (o_tlast[2]),
    .output_2_axis_tuser  (o_tuser[2]),
    .output_3_axis_tdata  (o_tdata[3]),
    .output_3_axis_tkeep  (o_tkeep[3]),
    .output_3_axis_tvalid (o_tvalid[3]),
    .output_3_axis_tready (o_tready[3]),
    .output_3_axis_tlast  (o_tlast[3]),
    .output_3_axis_tuser  (o_tuser[3])
  );

  task automatic chk(input string tag, input logic [75:0] observed, input logic [75:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_int(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [75:0] beat(input logic [1:0] p, input logic u, input logic l,
                                       input logic [7:0] k, input logic [63:0] d);
    return {p, u, l, k, d};
  endfunction

  // Output side: record every completed beat with its port, check one-hot
  // tvalid, and check that a stalled beat is held unchanged.
  always @(negedge clk) begin
    if (!rst) begin
      chk_int("tvalid_onehot", ($countones(o_tvalid) <= 1) ? 1 : 0, 1);
      for (int n = 0; n < 4; n++) begin
        if (stall_prev[n])
          chk("stall_hold", {1'b0, o_tvalid[n], o_tuser[n], o_tlast[n], o_tkeep[n], o_tdata[n]},
              held_beat[n]);
        if (o_tvalid[n]) vcount[n]++;
        if (o_tvalid[n] && o_tready[n])
          obs.push_back(beat(2'(n), o_tuser[n], o_tlast[n], o_tkeep[n], o_tdata[n]));
        stall_prev[n] = o_tvalid[n] && !o_tready[n];
        held_beat[n]  = {1'b0, o_tvalid[n], o_tuser[n], o_tlast[n], o_tkeep[n], o_tdata[n]};
      end
    end else begin
      for (int n = 0; n < 4; n++) stall_prev[n] = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int i, input int n, input logic [63:0] base, input logic [63:0] stride,
                          input logic [7:0] keep, input logic user_last);
    in_tdata = base + 64'(i) * stride;
    in_tkeep = keep;
    in_tlast = (i == n - 1);
    in_tuser = user_last && (i == n - 1);
  endtask

  // Offers one frame with tvalid held high; leaves tvalid asserted on return
  // so a following call produces a back-to-back frame.
  task automatic drive_frame(input logic [1:0] sel, input logic drp, input int n,
                             input logic [63:0] base, input logic [63:0] stride,
                             input logic [7:0] keep, input logic user_last,
                             input int chg_at, input logic [1:0] chg_sel, input logic [1:0] exp_port);
    int  i = 0;
    int  cyc = 0;
    logic x;
    first_x = -1; last_x = -1; n_x = 0;
    enable = 1'b1; select = sel; drop = drp; in_tvalid = 1'b1;
    set_beat(0, n, base, stride, keep, user_last);
    while (i < n && cyc < 400) begin
      x = in_tready;
      tick();
      if (x) begin
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        n_x++;
        if (chk_first && i == 0) begin
          chk("first_tvalid", 76'(o_tvalid), 76'(4'b0001 << exp_port));
          chk("first_tdata", 76'(o_tdata[exp_port]), 76'(base));
        end
        i++;
        if (i == chg_at) select = chg_sel;
        if (i < n) set_beat(i, n, base, stride, keep, user_last);
      end
      if (toggle0) o_tready[0] = ~o_tready[0];
      cyc++;
    end
    chk_int("frame_accepted", i, n);
  endtask

  task automatic stop_input();
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    in_tuser  = 1'b0;
    enable    = 1'b0;
  endtask

  task automatic wait_obs(input int target);
    int c = 0;
    while (obs.size() < target && c < 200) begin
      tick();
      if (toggle0) o_tready[0] = ~o_tready[0];
      c++;
    end
    chk_int("drain_count", obs.size(), target);
  endtask

  initial begin
    int s;
    int vs [4];
    for (int n = 0; n < 4; n++) begin vcount[n] = 0; stall_prev[n] = 1'b0; held_beat[n] = '0; end

    // Reset and enable gating
    rst = 1'b1;
    tick(); tick();
    chk("rst_tvalid", 76'(o_tvalid), 76'(4'b0000));
    chk("rst_tready", 76'(in_tready), 76'(1'b0));
    rst = 1'b0;
    enable = 1'b0;
    in_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("enable0_tready", 76'(in_tready), 76'(1'b0));
    end
    chk("enable0_tvalid", 76'(o_tvalid), 76'(4'b0000));
    stop_input();
    tick();

    // 3-beat frame to output 2
    s = obs.size();
    for (int n = 0; n < 4; n++) vs[n] = vcount[n];
    chk_first = 1'b1;
    drive_frame(2'd2, 1'b0, 3, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 8'h0F, 1'b0,
                99, 2'd0, 2'd2);
    chk_first = 1'b0;
    stop_input();
    chk_int("start_latency", first_x, 1);
    wait_obs(s + 3);
    chk("sel2_beat0", obs[s],     beat(2'd2, 1'b0, 1'b0, 8'h0F, 64'h1111_1111_1111_1111));
    chk("sel2_beat1", obs[s + 1], beat(2'd2, 1'b0, 1'b0, 8'h0F, 64'h2222_2222_2222_2222));
    chk("sel2_beat2", obs[s + 2], beat(2'd2, 1'b0, 1'b1, 8'h0F, 64'h3333_3333_3333_3333));
    chk_int("sel2_port0_quiet", vcount[0] - vs[0], 0);
    chk_int("sel2_port1_quiet", vcount[1] - vs[1], 0);
    chk_int("sel2_port3_quiet", vcount[3] - vs[3], 0);
    tick(); tick();

    // select changed mid-frame: frame stays on 2, next frame goes to 1
    s = obs.size();
    drive_frame(2'd2, 1'b0, 3, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 8'h0F, 1'b0,
                1, 2'd1, 2'd2);
    drive_frame(2'd1, 1'b0, 2, 64'hA0A0_A0A0_0000_0000, 64'h1, 8'hFF, 1'b0, 99, 2'd0, 2'd1);
    stop_input();
    wait_obs(s + 5);
    chk("midsel_beat0", obs[s],     beat(2'd2, 1'b0, 1'b0, 8'h0F, 64'h1111_1111_1111_1111));
    chk("midsel_beat1", obs[s + 1], beat(2'd2, 1'b0, 1'b0, 8'h0F, 64'h2222_2222_2222_2222));
    chk("midsel_beat2", obs[s + 2], beat(2'd2, 1'b0, 1'b1, 8'h0F, 64'h3333_3333_3333_3333));
    chk("next_sel1_beat0", obs[s + 3], beat(2'd1, 1'b0, 1'b0, 8'hFF, 64'hA0A0_A0A0_0000_0000));
    chk("next_sel1_beat1", obs[s + 4], beat(2'd1, 1'b0, 1'b1, 8'hFF, 64'hA0A0_A0A0_0000_0001));
    tick(); tick();

    // 8-beat dropped frame
    s = obs.size();
    for (int n = 0; n < 4; n++) vs[n] = vcount[n];
    drive_frame(2'd3, 1'b1, 8, 64'hDEAD_0000_0000_0000, 64'h1, 8'hFF, 1'b0, 99, 2'd0, 2'd3);
    stop_input();
    chk_int("drop_beats", n_x, 8);
    chk_int("drop_ready_run", last_x - first_x + 1, 8);
    tick(); tick(); tick();
    chk_int("drop_no_beats", obs.size(), s);
    chk_int("drop_no_tvalid", (vcount[0] - vs[0]) + (vcount[1] - vs[1]) +
                              (vcount[2] - vs[2]) + (vcount[3] - vs[3]), 0);

    // 16 beats to output 0 with tready toggling every cycle
    s = obs.size();
    o_tready[0] = 1'b1;
    toggle0 = 1'b1;
    drive_frame(2'd0, 1'b0, 16, 64'hC000_0000_0000_0000, 64'h1, 8'hFF, 1'b0, 99, 2'd0, 2'd0);
    stop_input();
    wait_obs(s + 16);
    toggle0 = 1'b0;
    o_tready[0] = 1'b1;
    for (int i = 0; i < 16; i++)
      chk("stall_order", obs[s + i],
          beat(2'd0, 1'b0, (i == 15), 8'hFF, 64'hC000_0000_0000_0000 + 64'(i)));
    tick(); tick();

    // back-to-back frames to outputs 3 then 0, tuser on last beat of the first
    s = obs.size();
    chk_first = 1'b1;
    drive_frame(2'd3, 1'b0, 2, 64'hD100_0000_0000_0000, 64'h1, 8'hFF, 1'b1, 99, 2'd0, 2'd3);
    drive_frame(2'd0, 1'b0, 2, 64'hE100_0000_0000_0000, 64'h1, 8'hFF, 1'b0, 99, 2'd0, 2'd0);
    chk_first = 1'b0;
    chk_int("b2b_dead_cycle", first_x, 1);
    stop_input();
    wait_obs(s + 4);
    chk("b2b_f1_beat0", obs[s],     beat(2'd3, 1'b0, 1'b0, 8'hFF, 64'hD100_0000_0000_0000));
    chk("b2b_f1_beat1", obs[s + 1], beat(2'd3, 1'b1, 1'b1, 8'hFF, 64'hD100_0000_0000_0001));
    chk("b2b_f2_beat0", obs[s + 2], beat(2'd0, 1'b0, 1'b0, 8'hFF, 64'hE100_0000_0000_0000));
    chk("b2b_f2_beat1", obs[s + 3], beat(2'd0, 1'b0, 1'b1, 8'hFF, 64'hE100_0000_0000_0001));
    tick(); tick();
    chk("idle_tvalid", 76'(o_tvalid), 76'(4'b0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
